sched_gen_6: RTL

Schedule generator that sits directly upstream of the 6-D address generator. It tracks its own 6-D iteration counters against a free-running cycle counter and emits `valid_output`, wired to the address generator's `step`. The pulse fires on exactly the cycles given by the affine schedule `starting_cycle + sum(loop_idx[i]*sched_strides[i])`. It also reports `done` after the last point of the iteration domain.

---
 rtl/sched_gen_6_pkg.sv | 10 +
 rtl/sched_gen_6_if.sv | 21 ++
 rtl/sched_gen_6_loop_iter.sv | 36 +++
 rtl/sched_gen_6.sv | 46 ++++
 4 files changed

// File: rtl/sched_gen_6_pkg.sv
// lake_sched_pkg: shared constants, counter/vector types and dimensionality clamp for the schedule generator
package lake_sched_pkg;
  localparam int NUM_DIMS = 6;
  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef cnt_t [NUM_DIMS-1:0] dim_vec_t;
  function automatic logic [2:0] clamp_dims(input logic [3:0] d);
    return d > 4'd6 ? 3'd6 : d[2:0];
  endfunction
endpackage

// File: rtl/sched_gen_6_if.sv
// sched_gen_6_if: schedule bundle; master drives clk_en/flush/dimensionality/ranges/sched_strides/starting_cycle, slave returns valid_output/done/cycle_count
interface sched_gen_6_if;
  import lake_sched_pkg::*;
  logic clk_en;
  logic flush;
  logic [3:0] dimensionality;
  dim_vec_t ranges;
  dim_vec_t sched_strides;
  cnt_t starting_cycle;
  logic valid_output;
  logic done;
  cnt_t cycle_count;
  modport master (
    output clk_en, flush, dimensionality, ranges, sched_strides, starting_cycle,
    input  valid_output, done, cycle_count
  );
  modport slave (
    input  clk_en, flush, dimensionality, ranges, sched_strides, starting_cycle,
    output valid_output, done, cycle_count
  );
endinterface

// File: rtl/sched_gen_6_loop_iter.sv
// loop_iter_6: 6-D iteration counters; in clk/rst/clk_en/step/flush/ranges/dims, out dim_counter/active/update/at_max/last
module loop_iter_6
  import lake_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                step,
  input  logic                flush,
  input  dim_vec_t            ranges,
  input  logic [2:0]          dims,
  output dim_vec_t            dim_counter,
  output logic [NUM_DIMS-1:0] active,
  output logic [NUM_DIMS-1:0] update,
  output logic [NUM_DIMS-1:0] at_max,
  output logic                last
);
  logic carry;
  always_comb begin
    carry = step;
    last = 1'b0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      active[i] = 3'(i) < dims;
      at_max[i] = dim_counter[i] == cnt_t'(ranges[i] - 1'b1);
      update[i] = carry;
      last = last | (carry & at_max[i] & (3'(i + 1) == dims));
      carry = carry & at_max[i];
    end
  end
  always_ff @(posedge clk)
    if (rst) dim_counter <= '0;
    else if (clk_en && flush) dim_counter <= '0;
    else if (clk_en)
      for (int i = 0; i < NUM_DIMS; i++)
        if (update[i] && active[i]) dim_counter[i] <= at_max[i] ? '0 : dim_counter[i] + 1'b1;
endmodule

// File: rtl/sched_gen_6.sv
// sched_gen_6: affine schedule step generator; in clk/rst + bus.slave config, out valid_output/done/cycle_count
module sched_gen_6
  import lake_sched_pkg::*;
(
  input logic clk,
  input logic rst,
  sched_gen_6_if.slave bus
);
  dim_vec_t sched_loc;
  dim_vec_t dim_counter;
  logic [NUM_DIMS-1:0] active, update, at_max;
  logic [2:0] dims;
  logic last, done, step;
  cnt_t cycle_count, sched_time;
  assign dims = clamp_dims(bus.dimensionality);
  loop_iter_6 u_iter (
    .clk(clk), .rst(rst), .clk_en(bus.clk_en), .step(step), .flush(bus.flush),
    .ranges(bus.ranges), .dims(dims), .dim_counter(dim_counter), .active(active),
    .update(update), .at_max(at_max), .last(last)
  );
  always_comb begin
    sched_time = bus.starting_cycle;
    for (int i = 0; i < NUM_DIMS; i++) sched_time = sched_time + (active[i] ? sched_loc[i] : '0);
    step = bus.clk_en & ~bus.flush & ~done & (dims != 3'd0) & (cycle_count == sched_time);
  end
  // sched_loc mirrors dim_counter scaled by the stride, so no multiplier is needed
  always_ff @(posedge clk)
    if (rst) begin
      cycle_count <= '0;
      sched_loc <= '0;
      done <= 1'b0;
    end else if (bus.clk_en) begin
      cycle_count <= bus.flush ? '0 : cycle_count + 1'b1;
      if (bus.flush) begin
        sched_loc <= '0;
        done <= 1'b0;
      end else begin
        if (last) done <= 1'b1;
        for (int i = 0; i < NUM_DIMS; i++)
          if (update[i] && active[i]) sched_loc[i] <= at_max[i] ? '0 : sched_loc[i] + bus.sched_strides[i];
      end
    end
  assign bus.valid_output = step;
  assign bus.done = done;
  assign bus.cycle_count = cycle_count;
endmodule
